// File: rtl/interface_wheel_gen_pkg.sv
// Shared definitions for the wheel A/B quadrature generator: FSM states,
// direction encoding and the per-direction A/B phase tables.
package interface_wheel_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } dir_t;

    // Returns {A,B} for the given direction and phase index.
    function automatic logic [1:0] ab_table(input dir_t d, input logic [1:0] p);
        logic [1:0] ab;
        ab = 2'b00;
        if (d == DIR_CW) begin
            case (p)
                2'd0:    ab = 2'b10;
                2'd1:    ab = 2'b11;
                2'd2:    ab = 2'b01;
                default: ab = 2'b00;
            endcase
        end else begin
            case (p)
                2'd0:    ab = 2'b01;
                2'd1:    ab = 2'b11;
                2'd2:    ab = 2'b10;
                default: ab = 2'b00;
            endcase
        end
        return ab;
    endfunction

endpackage

// File: rtl/interface_wheel_gen_if.sv
// Request/response bundle of the wheel generator: command inputs plus the
// emitted A/B lines, status and position.
interface interface_wheel_gen_if #(
    parameter int STEP_W = 8,
    parameter int POS_W  = 8
);
    logic              start;
    logic              dir;
    logic [STEP_W-1:0] steps;
    logic              stop;
    logic              A;
    logic              B;
    logic              busy;
    logic              done;
    logic [POS_W-1:0]  position;

    modport master (
        output start, dir, steps, stop,
        input  A, B, busy, done, position
    );

    modport slave (
        input  start, dir, steps, stop,
        output A, B, busy, done, position
    );
endinterface

// File: rtl/interface_wheel_gen_uc.sv
// Control FSM of the wheel generator: request acceptance, sticky graceful
// stop, and busy/done status.
module interface_wheel_gen_uc
    import interface_wheel_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic steps_zero,
    input  logic stop,
    input  logic cycle_end,
    input  logic last_step,
    output logic busy,
    output logic done,
    output logic launch,
    output logic rewind
);
    state_t state, state_next;
    logic   stop_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            stop_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE)
                stop_flag <= 1'b0;
            else if (state == ST_RUN && stop)
                stop_flag <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        rewind     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (steps_zero) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next = ST_RUN;
                        launch     = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // A stop arriving on the last edge of a cycle still ends the request there.
                if (cycle_end) begin
                    if (last_step || stop_flag || stop)
                        state_next = ST_FINISH;
                    else
                        rewind = 1'b1;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_FINISH);

endmodule

// File: rtl/interface_wheel_gen.sv
// Quadrature encoder emulator: emits N full A/B cycles in the commanded
// direction and tracks the signed emitted-edge position.
module interface_wheel_gen
    import interface_wheel_gen_pkg::*;
#(
    parameter int PHASE_CLKS = 2,
    parameter int STEP_W     = 8,
    parameter int POS_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    interface_wheel_gen_if.slave   bus
);
    localparam int TW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;

    logic [TW-1:0]     timer;
    logic [1:0]        phase;
    logic [STEP_W-1:0] remaining;
    logic [POS_W-1:0]  position;
    logic [1:0]        ab;
    dir_t              dir_q;

    logic phase_end, cycle_end, last_step, steps_zero;
    logic busy, done, launch, rewind;

    assign phase_end  = (timer == TW'(PHASE_CLKS - 1));
    assign cycle_end  = busy && phase_end && (phase == 2'd3);
    assign last_step  = (remaining == STEP_W'(1));
    assign steps_zero = (bus.steps == '0);

    interface_wheel_gen_uc u_uc (
        .clk        (clk),
        .reset      (reset),
        .start      (bus.start),
        .steps_zero (steps_zero),
        .stop       (bus.stop),
        .cycle_end  (cycle_end),
        .last_step  (last_step),
        .busy       (busy),
        .done       (done),
        .launch     (launch),
        .rewind     (rewind)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            phase     <= '0;
            remaining <= '0;
            position  <= '0;
            ab        <= '0;
            dir_q     <= DIR_CW;
        end else if (launch) begin
            dir_q     <= dir_t'(bus.dir);
            remaining <= bus.steps;
            phase     <= '0;
            timer     <= '0;
            ab        <= ab_table(dir_t'(bus.dir), 2'd0);
            position  <= bus.dir ? position - POS_W'(1) : position + POS_W'(1);
        end else if (busy) begin
            if (phase_end) begin
                timer <= '0;
                if (phase != 2'd3) begin
                    phase <= phase + 2'd1;
                    ab    <= ab_table(dir_q, phase + 2'd1);
                end else begin
                    // Cycle complete at AB=00; only a further cycle moves the lines again.
                    remaining <= remaining - STEP_W'(1);
                    phase     <= '0;
                    if (rewind) begin
                        ab       <= ab_table(dir_q, 2'd0);
                        position <= (dir_q == DIR_CCW) ? position - POS_W'(1)
                                                       : position + POS_W'(1);
                    end
                end
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign bus.A        = ab[1];
    assign bus.B        = ab[0];
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.position = position;

endmodule

// File: tb/tb_interface_wheel_gen.sv
// Self-checking bench for interface_wheel_gen: directed and randomized
// requests against a waveform model, plus an A/B decoder scoreboard.
module tb_interface_wheel_gen;
    localparam int P = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    interface_wheel_gen_if #(.STEP_W(8), .POS_W(8)) m  ();
    interface_wheel_gen_if #(.STEP_W(8), .POS_W(4)) m2 ();

    interface_wheel_gen #(.PHASE_CLKS(P), .STEP_W(8), .POS_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    interface_wheel_gen #(.PHASE_CLKS(1), .STEP_W(8), .POS_W(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (m2.slave)
    );

    always #5 clk = ~clk;

    logic [1:0] cw_seq  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ccw_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [7:0] model_pos = 8'd0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decoder scoreboard: single-bit transitions only, position tracks A-rising edges.
    logic       rst_seen = 1'b1;
    logic [1:0] prev_ab;
    logic [7:0] dec_pos;
    always @(posedge clk) rst_seen <= reset;
    always @(negedge clk) begin
        logic [1:0] cur;
        cur = {m.A, m.B};
        if (rst_seen) begin
            dec_pos = 8'd0;
        end else if (cur !== prev_ab) begin
            check("gray", {15'b0, (cur[1] ^ prev_ab[1]) & (cur[0] ^ prev_ab[0])}, 16'd0);
            if (!prev_ab[1] && cur[1])
                dec_pos = cur[0] ? dec_pos - 8'd1 : dec_pos + 8'd1;
            if (cur == 2'b00)
                check("decode_pos", {8'b0, m.position}, {8'b0, dec_pos});
        end
        prev_ab = cur;
    end

    // One request: stop_c / extra_c are cycle numbers after start (0 = none).
    task automatic run_req(input logic d, input int n_steps, input int stop_c, input int extra_c);
        int n, total;
        logic [1:0] exp_ab;
        n = n_steps;
        if (stop_c > 0 && ((stop_c - 1) / (4 * P)) + 1 < n)
            n = ((stop_c - 1) / (4 * P)) + 1;
        total = n * 4 * P;
        m.start = 1'b1;
        m.dir   = d;
        m.steps = n_steps[7:0];
        tick();
        m.start = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            if (c <= total) begin
                exp_ab = d ? ccw_seq[((c - 1) / P) % 4] : cw_seq[((c - 1) / P) % 4];
                check("run_ab_busy_done", {12'b0, m.A, m.B, m.busy, m.done}, {12'b0, exp_ab, 2'b10});
            end else begin
                check("finish_done", {12'b0, m.A, m.B, m.busy, m.done}, 16'b0001);
            end
            m.stop  = (c == stop_c);
            m.start = (c == extra_c);
            m.dir   = 1'($urandom);
            m.steps = 8'($urandom);
            tick();
        end
        m.stop  = 1'b0;
        m.start = 1'b0;
        check("back_idle", {12'b0, m.A, m.B, m.busy, m.done}, 16'b0000);
        model_pos = d ? model_pos - 8'(n) : model_pos + 8'(n);
        check("position", {8'b0, m.position}, {8'b0, model_pos});
    endtask

    task automatic run2(input logic d, input int n_steps, input logic [3:0] want);
        bit seen;
        seen = 1'b0;
        m2.start = 1'b1;
        m2.dir   = d;
        m2.steps = n_steps[7:0];
        tick();
        m2.start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (m2.done) seen = 1'b1;
            else tick();
        end
        check("pos4_done_seen", {15'b0, seen}, 16'd1);
        tick();
        check("pos4_wrap", {12'b0, m2.position}, {12'b0, want});
    endtask

    initial begin
        m.start = 1'b0; m.dir = 1'b0; m.steps = '0; m.stop = 1'b0;
        m2.start = 1'b0; m2.dir = 1'b0; m2.steps = '0; m2.stop = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("reset_outputs", {12'b0, m.A, m.B, m.busy, m.done}, 16'b0000);
        check("reset_position", {8'b0, m.position}, 16'd0);
        reset = 1'b0;
        tick();

        run_req(1'b0, 1, 0, 0);                 // single CW cycle
        run_req(1'b1, 3, 0, 0);                 // three CCW cycles
        run_req(1'b0, 0, 0, 0);                 // zero steps: done only
        run_req(1'b0, 5, 4 * P + P + 1, 3);     // stop in cycle 2 phase p1, ignored start
        run_req(1'b1, 2, 4 * P, 0);             // stop on the final edge of cycle 1

        for (int r = 0; r < 6; r++) begin
            logic rd;
            int   rn, rs;
            rd = 1'($urandom_range(0, 1));
            rn = int'($urandom_range(1, 5));
            rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rn * 4 * P)) : 0;
            run_req(rd, rn, rs, int'($urandom_range(2, 4)));
        end

        // Reset mid-run with AB=11
        m.start = 1'b1; m.dir = 1'b0; m.steps = 8'd4;
        tick();
        m.start = 1'b0;
        tick();
        tick();
        check("pre_reset_ab", {14'b0, m.A, m.B}, 16'b11);
        reset = 1'b1;
        tick();
        check("midrun_reset", {12'b0, m.A, m.B, m.busy, m.done}, 16'b0000);
        check("midrun_reset_pos", {8'b0, m.position}, 16'd0);
        reset = 1'b0;
        model_pos = 8'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_reset_quiet", {14'b0, m.busy, m.done}, 16'b00);
        end
        run_req(1'b1, 1, 0, 0);

        run2(1'b0, 9, 4'h9);
        run2(1'b1, 10, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
